// File: rtl/uart_tx_unit.sv
// UART transmitter: 11-bit frame (start, 8 data LSB first, parity slot, stop)
// with per-frame latched parity mode and bit rate.
module uart_tx_unit #(
    parameter int CLOCK_HZ = 50000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Send,
    input  logic [7:0] DataIn,
    input  logic [1:0] ParityType,
    input  logic [1:0] BaudRate,
    output logic       DataTx,
    output logic       Busy,
    output logic       Done
);

    localparam logic [14:0] DIV2400  = 15'(CLOCK_HZ / 2400);
    localparam logic [14:0] DIV4800  = 15'(CLOCK_HZ / 4800);
    localparam logic [14:0] DIV9600  = 15'(CLOCK_HZ / 9600);
    localparam logic [14:0] DIV19200 = 15'(CLOCK_HZ / 19200);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;

    txState_t    state, nextState;
    logic [14:0] bitCnt;
    logic [14:0] divReg;
    logic [14:0] divSel;
    logic [2:0]  bitIdx;
    logic [7:0]  shiftReg;
    logic        parityReg;
    logic        parityCalc;
    logic        accept;
    logic        bitEnd;
    logic        txNext;

    always_comb begin
        divSel = DIV2400;
        case (BaudRate)
            2'b00:   divSel = DIV2400;
            2'b01:   divSel = DIV4800;
            2'b10:   divSel = DIV9600;
            default: divSel = DIV19200;
        endcase
    end

    always_comb begin
        parityCalc = 1'b1;
        case (ParityType)
            2'b01:   parityCalc = ~^DataIn;
            2'b10:   parityCalc = ^DataIn;
            default: parityCalc = 1'b1;
        endcase
    end

    assign accept = (state == IDLE) && Send;
    assign bitEnd = (state != IDLE) && (bitCnt == divReg - 15'd1);

    always_comb begin
        Busy = (state != IDLE);
    end

    // Line value is computed for the state being entered so DataTx can be a register.
    always_comb begin
        nextState = state;
        txNext    = 1'b1;
        case (state)
            IDLE:    if (accept) nextState = START;
            START:   if (bitEnd) nextState = DATA;
            DATA:    if (bitEnd && bitIdx == 3'd7) nextState = PARITY;
            PARITY:  if (bitEnd) nextState = STOP;
            STOP:    if (bitEnd) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        case (nextState)
            IDLE:    txNext = 1'b1;
            START:   txNext = 1'b0;
            DATA:    txNext = (state == DATA && bitEnd) ? shiftReg[1] : shiftReg[0];
            PARITY:  txNext = parityReg;
            STOP:    txNext = 1'b1;
            default: txNext = 1'b1;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            bitCnt    <= '0;
            bitIdx    <= '0;
            divReg    <= '0;
            shiftReg  <= '0;
            parityReg <= 1'b1;
            DataTx    <= 1'b1;
            Done      <= 1'b0;
        end else begin
            state  <= nextState;
            DataTx <= txNext;
            Done   <= (state == STOP) && bitEnd;
            if (accept) begin
                shiftReg  <= DataIn;
                parityReg <= parityCalc;
                divReg    <= divSel;
                bitIdx    <= '0;
                bitCnt    <= '0;
            end else if (state != IDLE) begin
                bitCnt <= bitEnd ? '0 : bitCnt + 15'd1;
                if (state == DATA && bitEnd) begin
                    shiftReg <= {1'b0, shiftReg[7:1]};
                    bitIdx   <= bitIdx + 3'd1;
                end
            end
        end
    end

endmodule
